// File: rtl/intf_chk_pkg.sv
// Shared types and helpers for the interface val checker.
package intf_chk_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      CHECK  = 2'd2,
      DONE   = 2'd3
   } chk_state_t;

   // Width needed to index n items, never less than one bit.
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/intf_chk_prienc.sv
// Lowest-set-bit priority encoder; found flags any set bit.
module intf_chk_prienc #(
   parameter int unsigned WIDTH = 3,
   parameter int unsigned IDX_W = 2
) (
   input  logic [WIDTH-1:0] in_bits,
   output logic [IDX_W-1:0] idx,
   output logic             found
);

   // Scan upward and latch the first set bit seen.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (in_bits[i] && !found) begin
            idx   = IDX_W'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/intf_val_checker.sv
// Samples the packed val bits of generate-scoped intf instances over a
// check window after a settle delay and reports pass/fail statistics.
module intf_val_checker
   import intf_chk_pkg::*;
#(
   parameter int unsigned         NUM_INTF      = 3,
   parameter logic [NUM_INTF-1:0] EXPECT        = '1,
   parameter int unsigned         SETTLE_CYCLES = 2,
   parameter int unsigned         CHECK_CYCLES  = 8,
   parameter int unsigned         CNT_W         = 8,
   localparam int unsigned        IDX_W         = clog2_min1(NUM_INTF)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [NUM_INTF-1:0] vals,
   output logic                busy,
   output logic                done,
   output logic                pass,
   output logic [CNT_W-1:0]    err_count,
   output logic                first_bad_valid,
   output logic [IDX_W-1:0]    first_bad_idx
);

   localparam int unsigned SCNT_W = clog2_min1(SETTLE_CYCLES + 1);
   localparam int unsigned CCNT_W = clog2_min1(CHECK_CYCLES + 1);

   chk_state_t          state;
   chk_state_t          state_nxt;
   logic [SCNT_W-1:0]   settle_cnt;
   logic [CCNT_W-1:0]   check_cnt;
   logic [NUM_INTF-1:0] mism;
   logic [IDX_W-1:0]    mism_idx;
   logic                mism_any;
   logic                accept;
   logic                settle_last;
   logic                check_last;

   // Mismatch is forced to zero outside CHECK so unknown vals never leak.
   assign mism        = (state == CHECK) ? (vals ^ EXPECT) : '0;
   assign accept      = start && ((state == IDLE) || (state == DONE));
   assign settle_last = (settle_cnt == SCNT_W'(1));
   assign check_last  = (check_cnt == CCNT_W'(1));
   assign busy        = (state == SETTLE) || (state == CHECK);
   assign done        = (state == DONE);

   intf_chk_prienc #(
      .WIDTH (NUM_INTF),
      .IDX_W (IDX_W)
   ) u_prienc (
      .in_bits (mism),
      .idx     (mism_idx),
      .found   (mism_any)
   );

   // Next-state selection; a start in DONE is accepted like one in IDLE.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE, DONE: begin
            if (accept)
               state_nxt = (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
            else
               state_nxt = IDLE;
         end
         SETTLE: if (settle_last) state_nxt = CHECK;
         CHECK:  if (check_last)  state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Settle and check window counters, both loaded on an accepted start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         settle_cnt <= '0;
         check_cnt  <= '0;
      end else if (accept) begin
         settle_cnt <= SCNT_W'(SETTLE_CYCLES);
         check_cnt  <= CCNT_W'(CHECK_CYCLES);
      end else if (state == SETTLE) begin
         if (settle_last) check_cnt  <= CCNT_W'(CHECK_CYCLES);
         else             settle_cnt <= settle_cnt - 1'b1;
      end else if (state == CHECK && !check_last) begin
         check_cnt <= check_cnt - 1'b1;
      end
   end

   // Result registers; pass folds in the final sample so it lines up with done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_count       <= '0;
         first_bad_valid <= 1'b0;
         first_bad_idx   <= '0;
         pass            <= 1'b0;
      end else if (accept) begin
         err_count       <= '0;
         first_bad_valid <= 1'b0;
         first_bad_idx   <= '0;
         pass            <= 1'b0;
      end else if (state == CHECK) begin
         if (mism_any) begin
            if (err_count != '1) err_count <= err_count + 1'b1;
            if (!first_bad_valid) begin
               first_bad_valid <= 1'b1;
               first_bad_idx   <= mism_idx;
            end
         end
         if (check_last) pass <= (err_count == '0) && !mism_any;
      end
   end

endmodule
